fec_chain_sequencer: RTL
========================

// Module: fec_chain_sequencer
// PURPOSE
// - Sequences one message at a time through the FEC chain: input buffer -> encoder ->
//   modulator -> demodulator -> decoder -> output buffer.
// - Accepts ADC-side writes into the input buffer and DAC-side reads from the output buffer.
// - Drives per-stage en/req, consumes stage ack pulses. Pure control; no datapath.
// PARAMETERS
// - STAGE_TIMEOUT  256  max cycles a stage req may wait for ack (used only with FEC_SEQ_TIMEOUT_EN)
// - TMO_W          9    timeout counter width; must satisfy 2**TMO_W > STAGE_TIMEOUT
// PORTS
// - clk                 in   1  clock, all logic rising-edge
// - rst_n               in   1  asynchronous active-low reset
// - en                  in   1  chain enable; low = start no new message
// - req                 in   1  ADC-side write request (level)
// - ack                 out  1  1-cycle pulse: ADC word written to input buffer
// - dac_req             in   1  DAC-side read request (level)
// - dac_valid           out  1  1-cycle pulse: output-buffer data_out is valid
// - buff_empty_enc/full_enc/rd_valid_enc  in 1 each  input-buffer status
// - buff_empty_dec/full_dec/rd_valid_dec  in 1 each  output-buffer status
// - wr_en_buff_enc, rd_en_buff_enc        out 1 each  input-buffer strobes
// - wr_en_buff_dec, rd_en_buff_dec        out 1 each  output-buffer strobes
// - en_enc/en_mod/en_dem/en_dec           out 1 each  stage enables
// - req_enc/req_mod/req_dem/req_dec       out 1 each  stage requests (level)
// - ack_enc/ack_mod/ack_dem/ack_dec       in  1 each  stage acks (1-cycle pulse)
// - busy                out  1  high whenever FSM not in IDLE
// - err                 out  1  sticky stage-timeout flag
// BEHAVIOUR
// - Reset: every output 0, FSM = IDLE, timeout counter 0. Reset mid-message abandons it; no replay.
// - Ingress (independent of FSM): req & !buff_full_enc -> wr_en_buff_enc=1 for one cycle,
//   ack=1 the following cycle; req must drop or be re-qualified after ack (one write per ack).
//   req while full -> no strobe, no ack; req held until space.
// - Egress (independent of FSM): dac_req & !buff_empty_dec & no read outstanding ->
//   rd_en_buff_dec 1 cycle; dac_valid = rd_valid_dec registered through.
// - FSM states: IDLE, FETCH, WAIT_RDV, ENC, MOD, DEM, DEC, STORE.
//   IDLE -> FETCH when en & !buff_empty_enc.
//   FETCH: rd_en_buff_enc=1 for exactly one cycle -> WAIT_RDV.
//   WAIT_RDV -> ENC on rd_valid_enc.
//   ENC/MOD/DEM/DEC: en_x=1 and req_x=1 while in state; on ack_x, req_x drops next cycle and
//   FSM advances (ENC->MOD->DEM->DEC->STORE). One stage active at a time.
//   STORE: if !buff_full_dec, wr_en_buff_dec=1 one cycle -> IDLE; if full, hold (backpressure).
// - Stage ack seen outside its own state is ignored. en deassert mid-message: message completes.
// - Same-cycle ingress write and FETCH read allowed; buffer handles simultaneous wr/rd.
// - Min latency req to STORE strobe: 1 (write) + 1 (FETCH) + rd_valid delay + sum of stage
//   ack latencies + 1 per stage handoff.
// CONFIGURATION
// - FEC_SEQ_TIMEOUT_EN defined: counter clears on stage entry, increments each cycle in
//   ENC/MOD/DEM/DEC/WAIT_RDV; reaching STAGE_TIMEOUT drops req_x/en_x, sets err (sticky until
//   reset), FSM -> IDLE, message discarded.
// - Not defined: no counter, FSM waits indefinitely, err tied 0.
// TESTING
// - Single message: req 1 cycle with empty buffers, each stage acks after 3 cycles
//   -> ack once, req_enc..req_dec in order, one wr_en_buff_dec, busy low after STORE.
// - Input full: buff_full_enc=1, req high 10 cycles -> no wr_en_buff_enc, no ack; full drops
//   -> single write + ack.
// - Output backpressure: buff_full_dec=1 in STORE for 20 cycles -> FSM holds, no strobe;
//   release -> exactly one wr_en_buff_dec.
// - en low with non-empty input buffer -> FSM stays IDLE; en high -> FETCH next cycle.
// - Spurious ack_mod during ENC -> ignored, FSM stays ENC until ack_enc.
// - With FEC_SEQ_TIMEOUT_EN, STAGE_TIMEOUT=8, ack_dem never asserted -> req_dem drops after
//   8 cycles, err=1 and stays 1, FSM IDLE; async rst_n low mid-MOD -> all outputs 0 at once.

Source files
------------

// File: rtl/fec_chain_sequencer_if.sv
// Control bundle between the FEC chain sequencer and the blocks it drives:
// ADC/DAC handshakes, buffer status/strobes, per-stage en/req/ack.
interface fec_chain_sequencer_if;
  logic en;
  logic req;
  logic ack;
  logic dac_req;
  logic dac_valid;
  logic buff_empty_enc;
  logic buff_full_enc;
  logic rd_valid_enc;
  logic buff_empty_dec;
  logic buff_full_dec;
  logic rd_valid_dec;
  logic wr_en_buff_enc;
  logic rd_en_buff_enc;
  logic wr_en_buff_dec;
  logic rd_en_buff_dec;
  logic en_enc;
  logic en_mod;
  logic en_dem;
  logic en_dec;
  logic req_enc;
  logic req_mod;
  logic req_dem;
  logic req_dec;
  logic ack_enc;
  logic ack_mod;
  logic ack_dem;
  logic ack_dec;
  logic busy;
  logic err;

  modport master (
    input  en, req, dac_req,
    input  buff_empty_enc, buff_full_enc, rd_valid_enc,
    input  buff_empty_dec, buff_full_dec, rd_valid_dec,
    input  ack_enc, ack_mod, ack_dem, ack_dec,
    output ack, dac_valid,
    output wr_en_buff_enc, rd_en_buff_enc,
    output wr_en_buff_dec, rd_en_buff_dec,
    output en_enc, en_mod, en_dem, en_dec,
    output req_enc, req_mod, req_dem, req_dec,
    output busy, err
  );

  modport slave (
    output en, req, dac_req,
    output buff_empty_enc, buff_full_enc, rd_valid_enc,
    output buff_empty_dec, buff_full_dec, rd_valid_dec,
    output ack_enc, ack_mod, ack_dem, ack_dec,
    input  ack, dac_valid,
    input  wr_en_buff_enc, rd_en_buff_enc,
    input  wr_en_buff_dec, rd_en_buff_dec,
    input  en_enc, en_mod, en_dem, en_dec,
    input  req_enc, req_mod, req_dem, req_dec,
    input  busy, err
  );
endinterface

// File: rtl/fec_chain_sequencer.sv
// One-message-at-a-time sequencer for the FEC chain (pure control).
// Optional stage timeout enabled by defining FEC_SEQ_TIMEOUT_EN.
module fec_chain_sequencer #(
  parameter int STAGE_TIMEOUT = 256,
  parameter int TMO_W         = 9
) (
  input logic                   clk,
  input logic                   rst_n,
  fec_chain_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_RDV, ENC, MOD, DEM, DEC, STORE
  } state_t;

  state_t state;
  logic   rd_pend;
  logic   go;

  if (2**TMO_W <= STAGE_TIMEOUT) begin : g_bad_tmo_w
    $error("TMO_W too narrow for STAGE_TIMEOUT");
  end

  always_comb begin
    go = 1'b0;
    unique case (state)
      WAIT_RDV: go = bus.rd_valid_enc;
      ENC:      go = bus.ack_enc;
      MOD:      go = bus.ack_mod;
      DEM:      go = bus.ack_dem;
      DEC:      go = bus.ack_dec;
      default:  go = 1'b0;
    endcase
  end

  // Ingress/egress run beside the FSM; one write per ack, one read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_en_buff_enc <= 1'b0;
      bus.ack            <= 1'b0;
      bus.rd_en_buff_dec <= 1'b0;
      bus.dac_valid      <= 1'b0;
      rd_pend            <= 1'b0;
    end else begin
      bus.wr_en_buff_enc <= bus.req & ~bus.buff_full_enc
                          & ~bus.wr_en_buff_enc & ~bus.ack;
      bus.ack            <= bus.wr_en_buff_enc;
      bus.rd_en_buff_dec <= bus.dac_req & ~bus.buff_empty_dec
                          & ~rd_pend & ~bus.rd_en_buff_dec;
      rd_pend            <= (rd_pend | bus.rd_en_buff_dec)
                          & ~bus.rd_valid_dec;
      bus.dac_valid      <= bus.rd_valid_dec;
    end
  end

`ifdef FEC_SEQ_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(STAGE_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo;
  logic             timed;
  assign timed = state inside {WAIT_RDV, ENC, MOD, DEM, DEC};
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      bus.rd_en_buff_enc <= 1'b0;
      bus.wr_en_buff_dec <= 1'b0;
      bus.en_enc         <= 1'b0;
      bus.en_mod         <= 1'b0;
      bus.en_dem         <= 1'b0;
      bus.en_dec         <= 1'b0;
      bus.req_enc        <= 1'b0;
      bus.req_mod        <= 1'b0;
      bus.req_dem        <= 1'b0;
      bus.req_dec        <= 1'b0;
      bus.busy           <= 1'b0;
`ifdef FEC_SEQ_TIMEOUT_EN
      tmo                <= '0;
      bus.err            <= 1'b0;
`endif
    end else begin
      bus.rd_en_buff_enc <= 1'b0;
      bus.wr_en_buff_dec <= 1'b0;
      unique case (state)
        IDLE: if (bus.en && !bus.buff_empty_enc) begin
          state              <= FETCH;
          bus.rd_en_buff_enc <= 1'b1;
          bus.busy           <= 1'b1;
        end
        FETCH: state <= WAIT_RDV;
        WAIT_RDV: if (go) begin
          state       <= ENC;
          bus.en_enc  <= 1'b1;
          bus.req_enc <= 1'b1;
        end
        ENC: if (go) begin
          state       <= MOD;
          bus.en_enc  <= 1'b0;
          bus.req_enc <= 1'b0;
          bus.en_mod  <= 1'b1;
          bus.req_mod <= 1'b1;
        end
        MOD: if (go) begin
          state       <= DEM;
          bus.en_mod  <= 1'b0;
          bus.req_mod <= 1'b0;
          bus.en_dem  <= 1'b1;
          bus.req_dem <= 1'b1;
        end
        DEM: if (go) begin
          state       <= DEC;
          bus.en_dem  <= 1'b0;
          bus.req_dem <= 1'b0;
          bus.en_dec  <= 1'b1;
          bus.req_dec <= 1'b1;
        end
        DEC: if (go) begin
          state       <= STORE;
          bus.en_dec  <= 1'b0;
          bus.req_dec <= 1'b0;
        end
        STORE: if (!bus.buff_full_dec) begin
          state              <= IDLE;
          bus.wr_en_buff_dec <= 1'b1;
          bus.busy           <= 1'b0;
        end
        default: state <= IDLE;
      endcase
`ifdef FEC_SEQ_TIMEOUT_EN
      tmo <= (timed && !go) ? tmo + 1'b1 : '0;
      // A stuck stage abandons the message; ack on the last cycle still wins.
      if (timed && !go && tmo == TMO_LAST) begin
        state       <= IDLE;
        tmo         <= '0;
        bus.en_enc  <= 1'b0;
        bus.en_mod  <= 1'b0;
        bus.en_dem  <= 1'b0;
        bus.en_dec  <= 1'b0;
        bus.req_enc <= 1'b0;
        bus.req_mod <= 1'b0;
        bus.req_dem <= 1'b0;
        bus.req_dec <= 1'b0;
        bus.busy    <= 1'b0;
        bus.err     <= 1'b1;
      end
`endif
    end
  end

endmodule
